axil_wdata_fifo: RTL and testbench
==================================

# axil_wdata_fifo

Parametrised AXI4-Lite write-data channel buffer sitting between the slave port's W channel and the register-file write path. Accepts W beats (data and byte strobes) through a valid/ready handshake, holds up to DEPTH beats in order, and presents each head beat with strobe masking applied. Strobe masking either zero-fills disabled byte lanes or merges them with an externally supplied old word for read-modify-write. Supersedes the fixed 32-bit, unbuffered, single-mode write-data path.

## Interface

Parameters:
- DATA_WIDTH, 32, data bus width in bits; legal values 32 or 64. STRB_WIDTH = DATA_WIDTH/8.
- DEPTH, 4, FIFO entries; power of two, ≥ 2. CW = log2(DEPTH)+1.
- MERGE, 0, 0 = zero-fill disabled lanes; 1 = fill disabled lanes from i_MERGE_DATA.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  reset; synchronous, active-low.
- WVALID  in  1  upstream beat valid.
- WREADY  out  1  block can accept a beat.
- WDATA  in  DATA_WIDTH  upstream write data.
- WSTRB  in  STRB_WIDTH  upstream byte strobes; bit i enables WDATA[8i+7:8i].
- o_WVALID  out  1  head beat valid.
- i_WREADY  in  1  downstream accepts head beat.
- o_WDATA  out  DATA_WIDTH  masked or merged head data.
- o_WSTRB  out  STRB_WIDTH  head strobes, unmodified.
- i_MERGE_DATA  in  DATA_WIDTH  old word for merge; ignored when MERGE=0.
- o_COUNT  out  CW  number of stored beats.
- o_NULL_BEAT  out  1  head beat has WSTRB == 0.

## Operation

- Storage: circular buffer of DEPTH entries {WDATA, WSTRB}, write pointer wp, read pointer rp, counter cnt (0..DEPTH). Storage array is not reset.
- Push on ACLK edge when WVALID && WREADY: entry[wp] <= {WDATA, WSTRB}, wp <= wp+1 mod DEPTH.
- Pop on ACLK edge when o_WVALID && i_WREADY: rp <= rp+1 mod DEPTH.
- cnt: +1 on push only, −1 on pop only, unchanged on both or neither.
- WREADY = ARESETn && (cnt != DEPTH). Depends only on registered state, never on WVALID.
- o_WVALID = (cnt != 0). o_COUNT = cnt.
- Byte lane i of o_WDATA when o_WVALID=1:
  - strobe bit i = 1: head data lane i.
  - strobe bit i = 0, MERGE=0: 0x00.
  - strobe bit i = 0, MERGE=1: i_MERGE_DATA lane i.
- Combinational path from i_MERGE_DATA to o_WDATA is allowed.
- o_WDATA, o_WSTRB and o_NULL_BEAT are forced to 0 whenever o_WVALID=0.
- Null beats (WSTRB=0) are stored and popped like any other beat and are not dropped. o_NULL_BEAT flags them to the consumer.
- Upstream must hold WVALID, WDATA and WSTRB stable until accepted. The block does not check this.

## Timing

- Reset (ARESETn=0 at an edge): wp=rp=0, cnt=0. Stored beats are discarded, including mid-burst.
- While ARESETn=0: WREADY=0, o_WVALID=0, o_WDATA=0, o_WSTRB=0, o_COUNT=0, o_NULL_BEAT=0.
- First cycle after ARESETn rises: WREADY=1.
- Latency: a beat pushed at edge N is on o_WDATA/o_WVALID in the cycle after edge N, i.e. one cycle minimum.
- There is no same-cycle pass-through when empty.
- Full (cnt=DEPTH): WREADY=0. A pop at that edge frees one slot, and WREADY=1 the next cycle. There is no push-into-popping-slot bypass.
- Empty (cnt=0): pop is impossible. A push sets o_WVALID=1 next cycle.
- Simultaneous push and pop with 0<cnt<DEPTH: both occur and cnt is held. Sustains one beat per cycle.
- Pointers wrap from DEPTH−1 to 0 with no bubble.
- i_WREADY while o_WVALID=0 has no effect.

## Test plan

- Reset/idle: hold ARESETn=0 for 3 cycles with WVALID=1 -> WREADY=0, o_WVALID=0, o_COUNT=0. Release -> WREADY=1 next cycle.
- Fill/drain, DEPTH=4, i_WREADY=0: push 0x11111111…0x44444444 with WSTRB=0xF -> o_COUNT reaches 4 and WREADY=0. The 5th beat is held off. Then i_WREADY=1 -> outputs 0x11111111, 0x22222222, 0x33333333, 0x44444444 in order, and the 5th beat is accepted the cycle after the first pop.
- Zero-fill, MERGE=0: WDATA=0xAABBCCDD, WSTRB=0b0101 -> o_WDATA=0x00BB00DD, o_WSTRB=0b0101.
- Merge, MERGE=1: WDATA=0xAABBCCDD, WSTRB=0b1010, i_MERGE_DATA=0x12345678 -> o_WDATA=0xAA34CC78.
- Streaming and wrap: WVALID=1 and i_WREADY=1 continuously for 10 beats with incrementing data -> one beat out per cycle, no bubbles, o_COUNT stays at 1, pointers wrap twice, data intact.
- Null beat and mid-operation reset: push WSTRB=0 -> o_NULL_BEAT=1 and o_WDATA=0. With cnt=3, assert ARESETn=0 for one edge -> o_COUNT=0 and o_WVALID=0 next cycle, and old beats are never emitted.

Source files
------------

// File: rtl/axil_wdata_fifo.sv
// AXI4-Lite write-data channel buffer: in-order FIFO of W beats with per-lane
// strobe masking (zero-fill or merge with an old word) applied at the head.
module axil_wdata_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MERGE      = 0,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  localparam int unsigned CW         = $clog2(DEPTH) + 1
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  output logic                  o_WVALID,
  input  logic                  i_WREADY,
  output logic [DATA_WIDTH-1:0] o_WDATA,
  output logic [STRB_WIDTH-1:0] o_WSTRB,
  input  logic [DATA_WIDTH-1:0] i_MERGE_DATA,
  output logic [CW-1:0]         o_COUNT,
  output logic                  o_NULL_BEAT
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [STRB_WIDTH-1:0] strb_mem [DEPTH];

  logic [PW-1:0] wp_q;
  logic [PW-1:0] rp_q;
  logic [CW-1:0] cnt_q;

  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head_data;
  logic [STRB_WIDTH-1:0] head_strb;

  // Gating with ARESETn keeps every output quiet while reset is held, even
  // before the first reset edge has cleared the counter.
  assign WREADY   = ARESETn && (cnt_q != CW'(DEPTH));
  assign o_WVALID = ARESETn && (cnt_q != '0);
  assign o_COUNT  = ARESETn ? cnt_q : '0;

  assign push = WVALID && WREADY;
  assign pop  = o_WVALID && i_WREADY;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage is deliberately not reset; push is already blocked during reset.
  always_ff @(posedge ACLK) begin
    if (push) begin
      data_mem[wp_q] <= WDATA;
      strb_mem[wp_q] <= WSTRB;
    end
  end

  assign head_data = data_mem[rp_q];
  assign head_strb = strb_mem[rp_q];

  always_comb begin
    o_WDATA     = '0;
    o_WSTRB     = '0;
    o_NULL_BEAT = 1'b0;
    if (o_WVALID) begin
      o_WSTRB     = head_strb;
      o_NULL_BEAT = (head_strb == '0);
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (head_strb[i])    o_WDATA[8*i +: 8] = head_data[8*i +: 8];
        else if (MERGE != 0) o_WDATA[8*i +: 8] = i_MERGE_DATA[8*i +: 8];
        else                 o_WDATA[8*i +: 8] = 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_axil_wdata_fifo.sv
// Self-checking bench: a zero-fill and a merge instance share one stimulus and
// are compared every cycle against a queue-based model of the buffer.
module tb_axil_wdata_fifo;

  localparam int DW = 32;
  localparam int SW = 4;
  localparam int DEPTH = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic wvalid = 1'b0;
  logic iwready = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] mdata = '0;
  logic [SW-1:0] wstrb = '0;

  logic wready0, ovalid0, onull0, wready1, ovalid1, onull1;
  logic [DW-1:0] owdata0, owdata1;
  logic [SW-1:0] owstrb0, owstrb1;
  logic [CW-1:0] ocount0, ocount1;

  int checks = 0;
  int errors = 0;
  bit acc = 1'b0;

  logic [DW+SW-1:0] q[$];

  always #5 clk = ~clk;

  axil_wdata_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MERGE(0)) dut0 (
    .ACLK(clk), .ARESETn(rstn), .WVALID(wvalid), .WREADY(wready0), .WDATA(wdata),
    .WSTRB(wstrb), .o_WVALID(ovalid0), .i_WREADY(iwready), .o_WDATA(owdata0),
    .o_WSTRB(owstrb0), .i_MERGE_DATA(mdata), .o_COUNT(ocount0), .o_NULL_BEAT(onull0)
  );

  axil_wdata_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MERGE(1)) dut1 (
    .ACLK(clk), .ARESETn(rstn), .WVALID(wvalid), .WREADY(wready1), .WDATA(wdata),
    .WSTRB(wstrb), .o_WVALID(ovalid1), .i_WREADY(iwready), .o_WDATA(owdata1),
    .o_WSTRB(owstrb1), .i_MERGE_DATA(mdata), .o_COUNT(ocount1), .o_NULL_BEAT(onull1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] lanes(input logic [DW+SW-1:0] e, input bit merge,
                                          input logic [DW-1:0] md);
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [DW-1:0] r;
    d = e[DW+SW-1:SW];
    s = e[SW-1:0];
    r = '0;
    for (int i = 0; i < SW; i++)
      r[8*i +: 8] = s[i] ? d[8*i +: 8] : (merge ? md[8*i +: 8] : 8'h00);
    return r;
  endfunction

  // Model compare and update: outputs checked mid-low-phase, state advanced at the edge.
  initial begin
    bit ev, er, do_push, do_pop;
    int ec;
    logic [DW+SW-1:0] head;
    forever begin
      @(negedge clk);
      #2;
      ev = rstn && (q.size() != 0);
      er = rstn && (q.size() < DEPTH);
      ec = rstn ? q.size() : 0;
      head = ev ? q[0] : '0;
      chk("d0.wready", 64'(wready0), 64'(er));
      chk("d0.ovalid", 64'(ovalid0), 64'(ev));
      chk("d0.count", 64'(ocount0), 64'(ec));
      chk("d0.wdata", 64'(owdata0), ev ? 64'(lanes(head, 1'b0, mdata)) : 64'd0);
      chk("d0.wstrb", 64'(owstrb0), 64'(head[SW-1:0]));
      chk("d0.null", 64'(onull0), 64'(ev && head[SW-1:0] == '0));
      chk("d1.wready", 64'(wready1), 64'(er));
      chk("d1.ovalid", 64'(ovalid1), 64'(ev));
      chk("d1.count", 64'(ocount1), 64'(ec));
      chk("d1.wdata", 64'(owdata1), ev ? 64'(lanes(head, 1'b1, mdata)) : 64'd0);
      chk("d1.wstrb", 64'(owstrb1), 64'(head[SW-1:0]));
      chk("d1.null", 64'(onull1), 64'(ev && head[SW-1:0] == '0));
      @(posedge clk);
      if (!rstn) begin
        q.delete();
      end else begin
        do_pop  = (q.size() != 0) && iwready;
        do_push = wvalid && (q.size() < DEPTH);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back({wdata, wstrb});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    acc = wvalid && wready0;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // Reset held with WVALID asserted
    wvalid = 1'b1;
    wdata = 32'hCAFE0000;
    wstrb = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("rst.wready", 64'(wready0), 64'd0);
      chk("rst.ovalid", 64'(ovalid0), 64'd0);
      chk("rst.count", 64'(ocount0), 64'd0);
      step();
    end
    rstn = 1'b1;
    wvalid = 1'b0;
    #3;
    chk("rel.wready", 64'(wready0), 64'd1);

    // Fill to full with the consumer stalled
    iwready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      wvalid = 1'b1;
      wdata = 32'h11111111 * k;
      wstrb = 4'hF;
      step();
    end
    wdata = 32'h55555555;
    #3;
    chk("full.count", 64'(ocount0), 64'd4);
    chk("full.wready", 64'(wready0), 64'd0);
    step();
    chk("held.count", 64'(ocount0), 64'd4);
    iwready = 1'b1;
    #3;
    chk("drain0", 64'(owdata0), 64'h11111111);
    step();
    #3;
    chk("drain1", 64'(owdata0), 64'h22222222);
    chk("drain1.wready", 64'(wready0), 64'd1);
    chk("drain1.count", 64'(ocount0), 64'd3);
    step();
    wvalid = 1'b0;
    #3;
    chk("drain2", 64'(owdata0), 64'h33333333);
    chk("drain2.count", 64'(ocount0), 64'd3);
    step();
    #3;
    chk("drain3", 64'(owdata0), 64'h44444444);
    step();
    #3;
    chk("drain4", 64'(owdata0), 64'h55555555);
    chk("drain4.count", 64'(ocount0), 64'd1);
    step();
    #3;
    chk("empty.ovalid", 64'(ovalid0), 64'd0);

    // Zero-fill versus merge
    iwready = 1'b0;
    wvalid = 1'b1;
    wdata = 32'hAABBCCDD;
    wstrb = 4'b0101;
    mdata = 32'h12345678;
    step();
    wvalid = 1'b0;
    #3;
    chk("zfill.data", 64'(owdata0), 64'h00BB00DD);
    chk("zfill.strb", 64'(owstrb0), 64'h5);
    chk("merge0101.data", 64'(owdata1), 64'h12BB56DD);
    iwready = 1'b1;
    step();
    iwready = 1'b0;
    wvalid = 1'b1;
    wstrb = 4'b1010;
    step();
    wvalid = 1'b0;
    #3;
    chk("merge.data", 64'(owdata1), 64'hAA34CC78);
    chk("zfill1010.data", 64'(owdata0), 64'hAA00CC00);
    iwready = 1'b1;
    step();

    // Streaming across pointer wraps
    wvalid = 1'b1;
    iwready = 1'b1;
    wstrb = 4'hF;
    for (int k = 0; k < 10; k++) begin
      wdata = 32'h100 + 32'(k);
      step();
      #3;
      chk("stream.count", 64'(ocount0), 64'd1);
      chk("stream.data", 64'(owdata0), 64'h100 + 64'(k));
    end
    wvalid = 1'b0;
    step();

    // Null beat, then reset with three beats stored
    iwready = 1'b0;
    wvalid = 1'b1;
    wdata = 32'hDEADBEEF;
    wstrb = 4'h0;
    mdata = 32'h0BADF00D;
    step();
    #3;
    chk("null.flag", 64'(onull0), 64'd1);
    chk("null.data0", 64'(owdata0), 64'd0);
    chk("null.data1", 64'(owdata1), 64'h0BADF00D);
    wstrb = 4'hF;
    step();
    step();
    wvalid = 1'b0;
    #3;
    chk("pre_rst.count", 64'(ocount0), 64'd3);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    iwready = 1'b1;
    #3;
    chk("post_rst.count", 64'(ocount0), 64'd0);
    chk("post_rst.ovalid", 64'(ovalid0), 64'd0);
    step();
    step();

    // Randomised traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if (!(wvalid && !acc)) begin
        wvalid = ($urandom % 10) < 6;
        wdata = $urandom;
        wstrb = 4'($urandom);
        if ($urandom % 8 == 0) wstrb = 4'h0;
      end
      iwready = ($urandom % 10) < 6;
      mdata = $urandom;
      rstn = ($urandom % 60) != 0;
      step();
    end
    rstn = 1'b1;
    wvalid = 1'b0;
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
